// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a GRN node array.
// Drives reset_nos/start_s0/start_s1 into the nodes and watches the registered
// s0 (tortoise) and s1 (hare) buses. It reports the transient length mu, the
// attractor period lambda and the first state on the attractor.
module grn_attractor_ctrl #(
  parameter int unsigned N_NODES  = 8,
  parameter int unsigned CW       = 16,
  parameter int unsigned MAX_ITER = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  output logic               busy,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_state,
  input  logic [N_NODES-1:0] s1_state,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CW-1:0]      mu,
  output logic [CW-1:0]      lambda,
  output logic [N_NODES-1:0] attr_state,
  output logic               timeout
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StF1, StF2, StFchk, StP1, StPchk,
    StReload, StPre, StMchk, StMa, StMb, StDone
  } state_e;

  state_e state_q, state_d;

  logic [N_NODES-1:0] init_state_q, init_state_d;
  logic [N_NODES-1:0] attr_q, attr_d;
  logic [CW-1:0]      iter_q, iter_d;
  logic [CW-1:0]      lambda_q, lambda_d;
  logic [CW-1:0]      mu_q, mu_d;
  logic [CW-1:0]      pre_q, pre_d;
  logic               timeout_q, timeout_d;

  logic          states_eq;
  logic [CW-1:0] iter_inc;
  logic          pre_more;

  assign states_eq = (s0_state == s1_state);
  assign iter_inc  = iter_q + CW'(1);
  assign pre_more  = (pre_q < lambda_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   state_d = StF1;
      StF1:     state_d = StF2;
      StF2:     state_d = StFchk;
      StFchk: begin
        if (states_eq)                   state_d = StP1;
        else if (iter_inc == CW'(MAX_ITER)) state_d = StDone;
        else                             state_d = StF1;
      end
      StP1:     state_d = StPchk;
      StPchk:   state_d = states_eq ? StReload : StP1;
      StReload: state_d = StPre;
      StPre:    state_d = pre_more ? StPre : StMchk;
      StMchk:   state_d = states_eq ? StDone : StMa;
      StMa:     state_d = StMb;
      StMb:     state_d = StMchk;
      StDone:   if (res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath registers: counters and held results
  always_ff @(posedge clk) begin
    if (rst) begin
      init_state_q <= '0;
      attr_q       <= '0;
      iter_q       <= '0;
      lambda_q     <= '0;
      mu_q         <= '0;
      pre_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      init_state_q <= init_state_d;
      attr_q       <= attr_d;
      iter_q       <= iter_d;
      lambda_q     <= lambda_d;
      mu_q         <= mu_d;
      pre_q        <= pre_d;
      timeout_q    <= timeout_d;
    end
  end

  // Datapath next-state: counters advance only in their own phase
  always_comb begin
    init_state_d = init_state_q;
    attr_d       = attr_q;
    iter_d       = iter_q;
    lambda_d     = lambda_q;
    mu_d         = mu_q;
    pre_d        = pre_q;
    timeout_d    = timeout_q;
    case (state_q)
      StIdle: begin
        // Clear old results so a timeout run reports zeros everywhere
        if (start) begin
          init_state_d = init_vec;
          attr_d       = '0;
          iter_d       = '0;
          lambda_d     = '0;
          mu_d         = '0;
          timeout_d    = 1'b0;
        end
      end
      StFchk: begin
        iter_d = iter_inc;
        if (states_eq)                      lambda_d  = '0;
        else if (iter_inc == CW'(MAX_ITER)) timeout_d = 1'b1;
      end
      StP1:     lambda_d = lambda_q + CW'(1);
      StReload: pre_d = '0;
      StPre: begin
        if (pre_more) pre_d = pre_q + CW'(1);
        else          mu_d  = '0;
      end
      StMchk:   if (states_eq) attr_d = s0_state;
      StMb:     mu_d = mu_q + CW'(1);
      default: ;
    endcase
  end

  // Outputs: node pulses decoded from state, results from held registers
  always_comb begin
    reset_nos = (state_q == StLoad) || (state_q == StReload);
    start_s0  = (state_q == StF1) || (state_q == StF2) ||
                (state_q == StMa) || (state_q == StMb);
    start_s1  = (state_q == StF1) || (state_q == StF2) || (state_q == StP1) ||
                (state_q == StMa) || ((state_q == StPre) && pre_more);
    busy      = (state_q != StIdle);
    res_valid = (state_q == StDone);
  end

  assign init_state = init_state_q;
  assign attr_state = attr_q;
  assign mu         = mu_q;
  assign lambda     = lambda_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: two controllers (default limit and a limit of
// 4) drive behavioural 4-node stubs built from a lookup table f(). Expected
// results come from walking the trajectory and are queued; a monitor pops and
// compares on every result handshake.
module tb_grn_attractor_ctrl;

  localparam int NN = 4;
  localparam int CW = 16;
  localparam int LIM1 = 4;
  localparam int LIM0 = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic res_ready = 1'b1;
  logic [NN-1:0] init_vec = '0;
  logic [1:0] start = '0;

  logic [1:0] busy, reset_nos, start_s0, start_s1, res_valid, timeout;
  logic [1:0][NN-1:0] init_state, s0, s1, attr_state;
  logic [1:0][CW-1:0] mu, lambda;
  logic [1:0] pass;

  logic [NN-1:0] fmap [16];

  typedef struct {
    int dut;
    int tag;
    int mu;
    int lam;
    int attr;
    int to;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  grn_attractor_ctrl #(.N_NODES(NN), .CW(CW), .MAX_ITER(LIM0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .init_vec(init_vec), .busy(busy[0]),
    .reset_nos(reset_nos[0]), .init_state(init_state[0]), .start_s0(start_s0[0]),
    .start_s1(start_s1[0]), .s0_state(s0[0]), .s1_state(s1[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready), .mu(mu[0]), .lambda(lambda[0]), .attr_state(attr_state[0]),
    .timeout(timeout[0])
  );

  grn_attractor_ctrl #(.N_NODES(NN), .CW(CW), .MAX_ITER(LIM1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .init_vec(init_vec), .busy(busy[1]),
    .reset_nos(reset_nos[1]), .init_state(init_state[1]), .start_s0(start_s0[1]),
    .start_s1(start_s1[1]), .s0_state(s0[1]), .s1_state(s1[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready), .mu(mu[1]), .lambda(lambda[1]), .attr_state(attr_state[1]),
    .timeout(timeout[1])
  );

  // Node stub: registered s0/s1; s0 only moves on every other start_s0
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        s0[i] <= '0;
        s1[i] <= '0;
        pass[i] <= 1'b0;
      end else if (reset_nos[i]) begin
        s0[i] <= init_state[i];
        s1[i] <= init_state[i];
        pass[i] <= 1'b1;
      end else begin
        if (start_s0[i]) begin
          if (pass[i]) s0[i] <= fmap[s0[i]];
          pass[i] <= ~pass[i];
        end
        if (start_s1[i]) s1[i] <= fmap[s1[i]];
      end
    end
  end

  task automatic check(input string nm, input int tag, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s (test %0d): got %0d expected %0d", nm, tag, act, req);
    end
  endtask

  // Reference: walk the trajectory until a state repeats, then derive when
  // the tortoise/hare pair first meets to decide whether the limit is hit.
  function automatic exp_t ref_model(input int init, input int lim, input int dut, input int tag);
    exp_t e;
    int first [16];
    int traj [17];
    int x, k, m, mu_r, lam_r;
    for (int i = 0; i < 16; i++) first[i] = -1;
    x = init;
    k = 0;
    while (first[x] < 0) begin
      first[x] = k;
      traj[k] = x;
      x = int'(fmap[x]);
      k++;
    end
    mu_r = first[x];
    lam_r = k - mu_r;
    m = 1;
    while (m < mu_r || (m % lam_r) != 0) m++;
    e.dut = dut;
    e.tag = tag;
    if (m > lim) begin
      e.mu = 0; e.lam = 0; e.attr = 0; e.to = 1;
    end else begin
      e.mu = mu_r; e.lam = lam_r; e.attr = traj[mu_r]; e.to = 0;
    end
    return e;
  endfunction

  // Monitor: compare every accepted result against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (res_valid[i] && res_ready) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: dut %0d got result, expected none", i);
          end else begin
            e = expq.pop_front();
            check("result_dut", e.tag, i, e.dut);
            check("mu", e.tag, int'(mu[i]), e.mu);
            check("lambda", e.tag, int'(lambda[i]), e.lam);
            check("attr_state", e.tag, int'(attr_state[i]), e.attr);
            check("timeout", e.tag, int'(timeout[i]), e.to);
          end
        end
      end
    end
  end

  task automatic set_identity();
    for (int i = 0; i < 16; i++) fmap[i] = NN'(i);
  endtask

  task automatic set_incr();
    for (int i = 0; i < 16; i++) fmap[i] = NN'((i + 1) % 16);
  endtask

  task automatic set_case3();
    set_identity();
    fmap[0] = 4'd1; fmap[1] = 4'd2; fmap[2] = 4'd3; fmap[3] = 4'd2;
  endtask

  task automatic pulse_start(input int d, input int init);
    @(posedge clk); #1;
    init_vec = NN'(init);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int tag);
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      if (!busy[d]) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL run_timeout (test %0d): busy still 1 expected 0", tag);
    end
  endtask

  task automatic run(input int d, input int init, input int tag);
    expq.push_back(ref_model(init, (d == 0) ? LIM0 : LIM1, d, tag));
    pulse_start(d, init);
    wait_idle(d, tag);
  endtask

  initial begin
    exp_t e;
    bit seen;
    set_identity();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 0, int'(busy), 0);
    check("rst_pulses", 0, int'({reset_nos, start_s0, start_s1}), 0);
    check("rst_valid", 0, int'(res_valid), 0);
    check("rst_results", 0, int'({mu[0], lambda[0], attr_state[0], timeout[0]}), 0);

    set_identity(); run(0, 'hA, 1);
    set_incr();     run(0, 0, 2);
    set_case3();    run(0, 0, 3);
    set_incr();     run(1, 0, 4);

    // Result held while res_ready is low; start and init_vec changes ignored
    set_identity();
    res_ready = 1'b0;
    e = ref_model('hA, LIM0, 0, 5);
    expq.push_back(e);
    pulse_start(0, 'hA);
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(posedge clk); #1;
      if (res_valid[0]) seen = 1;
    end
    check("hold_reach_done", 5, int'(seen), 1);
    for (int c = 0; c < 10; c++) begin
      start[0] = c[0];
      init_vec = NN'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("hold_valid", 5, int'(res_valid[0]), 1);
      check("hold_busy", 5, int'(busy[0]), 1);
      check("hold_mu", 5, int'(mu[0]), e.mu);
      check("hold_lambda", 5, int'(lambda[0]), e.lam);
      check("hold_attr", 5, int'(attr_state[0]), e.attr);
      check("hold_init", 5, int'(init_state[0]), 'hA);
    end
    start[0] = 1'b0;
    res_ready = 1'b1;
    wait_idle(0, 5);
    @(posedge clk); #1;
    check("idle_after_hs", 5, int'({busy[0], res_valid[0]}), 0);

    // Reset during the period-counting phase of the 16-cycle ring
    set_incr();
    pulse_start(0, 0);
    seen = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(posedge clk); #1;
      if (start_s1[0] && !start_s0[0] && !reset_nos[0]) seen = 1;
    end
    check("reach_p1", 6, int'(seen), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ctrl", 6,
          int'({busy[0], reset_nos[0], start_s0[0], start_s1[0], res_valid[0], timeout[0]}), 0);
    check("midrst_mu_lambda", 6, int'({mu[0], lambda[0]}), 0);
    check("midrst_state", 6, int'({attr_state[0], init_state[0]}), 0);
    set_identity(); run(0, 'hA, 6);

    // Random maps on both controllers
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 16; i++) fmap[i] = NN'($urandom_range(0, 15));
      run(t % 2, $urandom_range(0, 15), 100 + t);
    end

    repeat (4) @(posedge clk);
    #1 check("queue_drained", 0, expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
